// File: rtl/unloadfsm_ne_if.sv
// Unload-side bus between the unload sequencer and its load side, decoder mux and output FIFO.
// The master modport is the sequencer. The slave modport is the surrounding logic.
interface unloadfsm_ne_if #(
  parameter int ADDRESSWIDTH = 9
);
  logic                    start;
  logic                    fifo_afull;
  logic                    unload_en;
  logic [ADDRESSWIDTH-1:0] UNLOADADDRESS;
  logic                    wr_en;
  logic [ADDRESSWIDTH-1:0] wr_addr;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, fifo_afull,
    output unload_en, UNLOADADDRESS, wr_en, wr_addr, busy, done
  );

  modport slave (
    output start, fifo_afull,
    input  unload_en, UNLOADADDRESS, wr_en, wr_addr, busy, done
  );
endinterface

// File: rtl/unloadfsm_ne.sv
// Unload sequencer: steps the decoded-word column select once per frame and
// mirrors it, one cycle later, into output-FIFO write strobes and addresses.
// It pauses on FIFO almost-full. It emits a stretched done level when the frame
// completes. A level start can never launch a second frame without first dropping.
module unloadfsm_ne #(
  parameter int ADDRESSWIDTH = 9,
  parameter int UNLOADCOUNT  = 16,
  parameter int DONE_STRETCH = 10
) (
  input  logic           clk,
  input  logic           rst,
  unloadfsm_ne_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    UNLOADING,
    STALL,
    FRAMEDONE,
    WAITSTARTLOW
  } state_t;

  localparam logic [ADDRESSWIDTH-1:0] LAST_COL = ADDRESSWIDTH'(UNLOADCOUNT - 1);
  localparam logic [ADDRESSWIDTH-1:0] ONE      = ADDRESSWIDTH'(1);

  state_t                  state, state_nx;
  logic                    vld_p0, vld_nx;
  logic [ADDRESSWIDTH-1:0] addr_p0, addr_nx;
  logic                    vld_p1;
  logic [ADDRESSWIDTH-1:0] addr_p1;
  logic [DONE_STRETCH-1:0] done_sr;
  logic                    frame_flag;

  // In UNLOADING the column in addr_p0 is presented this cycle. That column is
  // consumed even if almost-full rises now, because the FIFO slack absorbs it.
  // The stall therefore parks on the following column, so nothing is skipped or repeated.
  always_comb begin
    state_nx = state;
    vld_nx   = 1'b0;
    addr_nx  = addr_p0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.fifo_afull) begin
          state_nx = UNLOADING;
          vld_nx   = 1'b1;
          addr_nx  = '0;
        end
      end
      UNLOADING: begin
        if (addr_p0 == LAST_COL) begin
          state_nx = FRAMEDONE;
          addr_nx  = '0;
        end else begin
          addr_nx = addr_p0 + ONE;
          if (bus.fifo_afull) begin
            state_nx = STALL;
          end else begin
            vld_nx = 1'b1;
          end
        end
      end
      STALL: begin
        if (!bus.fifo_afull) begin
          state_nx = UNLOADING;
          vld_nx   = 1'b1;
        end
      end
      FRAMEDONE: begin
        state_nx = bus.start ? WAITSTARTLOW : IDLE;
      end
      WAITSTARTLOW: begin
        if (!bus.start) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Column-select stage: FSM state, column valid and column index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      vld_p0  <= 1'b0;
      addr_p0 <= '0;
    end else begin
      state   <= state_nx;
      vld_p0  <= vld_nx;
      addr_p0 <= addr_nx;
    end
  end

  // FIFO write stage: the decoder output for a selected column lands one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      addr_p1 <= addr_p0;
    end
  end

  assign frame_flag = (state == FRAMEDONE) || (state == WAITSTARTLOW);

  // The done stretcher keeps the level wide enough for the slower downstream domain to sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_sr <= '0;
    end else begin
      done_sr <= {done_sr[DONE_STRETCH-2:0], frame_flag};
    end
  end

  assign bus.unload_en     = vld_p0;
  assign bus.UNLOADADDRESS = addr_p0;
  assign bus.wr_en         = vld_p1;
  assign bus.wr_addr       = addr_p1;
  assign bus.busy          = (state != IDLE);
  assign bus.done          = |done_sr;

endmodule

// File: tb/tb_unloadfsm_ne.sv
// Testbench for unloadfsm_ne: a 16-column/10-stretch instance and a 2-column/2-stretch
// instance driven by the same start/almost-full/reset stimulus.
module tb_unloadfsm_ne;

  logic clk;
  logic rst_n;
  logic start;
  logic afull;

  unloadfsm_ne_if #(.ADDRESSWIDTH(9)) if1 ();
  unloadfsm_ne_if #(.ADDRESSWIDTH(9)) if2 ();

  assign if1.start      = start;
  assign if1.fifo_afull = afull;
  assign if2.start      = start;
  assign if2.fifo_afull = afull;

  unloadfsm_ne #(.ADDRESSWIDTH(9), .UNLOADCOUNT(16), .DONE_STRETCH(10)) u_dut1 (
    .clk (clk),
    .rst (rst_n),
    .bus (if1)
  );

  unloadfsm_ne #(.ADDRESSWIDTH(9), .UNLOADCOUNT(2), .DONE_STRETCH(2)) u_dut2 (
    .clk (clk),
    .rst (rst_n),
    .bus (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Each frame issues columns 0..N-1 in order. A column is issued
  // in the cycle after any cycle whose almost-full is low while the frame still owes columns.
  // Each write trails its column by one cycle.
  // The frame flag is raised once the last column is issued and is held while start stays high.
  // done is high if the flag was seen within the last DS edges.
  typedef struct {
    logic ue;
    int   addr;
    int   nxt;
    logic inframe;
    logic flag;
    logic wr;
    int   wraddr;
    int   edges;
    int   lf;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.ue = 1'b0; m.addr = 0; m.nxt = 0; m.inframe = 1'b0; m.flag = 1'b0;
    m.wr = 1'b0; m.wraddr = 0; m.edges = 0; m.lf = -1000000;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input logic st, input logic af, input int cols);
    mdl_t n;
    n = m;
    n.edges  = m.edges + 1;
    n.wr     = m.ue;
    n.wraddr = m.addr;
    n.ue     = 1'b0;
    if (m.flag) n.lf = n.edges;
    if (m.inframe) begin
      if (m.ue && (m.addr == cols - 1)) begin
        n.inframe = 1'b0;
        n.flag    = 1'b1;
      end else if (!af) begin
        n.ue   = 1'b1;
        n.addr = m.nxt;
        n.nxt  = m.nxt + 1;
      end
    end else if (m.flag) begin
      n.flag = st;
    end else if (st && !af) begin
      n.inframe = 1'b1;
      n.ue      = 1'b1;
      n.addr    = 0;
      n.nxt     = 1;
    end
    return n;
  endfunction

  mdl_t m1, m2;

  // Advance the models on each rising edge, using the inputs as sampled there.
  always @(posedge clk) begin
    if (!rst_n) begin
      m1 = mdl_reset();
      m2 = mdl_reset();
    end else begin
      m1 = mdl_step(m1, start, afull, 16);
      m2 = mdl_step(m2, start, afull, 2);
    end
  end

  task automatic cmp_dut(input string tag, input mdl_t m, input int ds,
                         input logic ue, input int a, input logic we, input int wa,
                         input logic b, input logic d);
    check({tag, "_unload_en"}, int'(ue), int'(m.ue));
    if (m.ue) check({tag, "_UNLOADADDRESS"}, a, m.addr);
    check({tag, "_wr_en"}, int'(we), int'(m.wr));
    if (m.wr) check({tag, "_wr_addr"}, wa, m.wraddr);
    check({tag, "_busy"}, int'(b), int'(m.inframe || m.flag));
    check({tag, "_done"}, int'(d), int'((m.edges - m.lf) < ds));
  endtask

  task automatic chk_zero(input string tag, input logic ue, input int a, input logic we,
                          input int wa, input logic b, input logic d);
    check({tag, "_unload_en"}, int'(ue), 0);
    check({tag, "_UNLOADADDRESS"}, a, 0);
    check({tag, "_wr_en"}, int'(we), 0);
    check({tag, "_wr_addr"}, wa, 0);
    check({tag, "_busy"}, int'(b), 0);
    check({tag, "_done"}, int'(d), 0);
  endtask

  // Compare every cycle on the falling edge, against zero while reset is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk_zero("rst1", if1.unload_en, int'(if1.UNLOADADDRESS), if1.wr_en, int'(if1.wr_addr), if1.busy, if1.done);
      chk_zero("rst2", if2.unload_en, int'(if2.UNLOADADDRESS), if2.wr_en, int'(if2.wr_addr), if2.busy, if2.done);
    end else begin
      cmp_dut("d1", m1, 10, if1.unload_en, int'(if1.UNLOADADDRESS), if1.wr_en, int'(if1.wr_addr), if1.busy, if1.done);
      cmp_dut("d2", m2, 2, if2.unload_en, int'(if2.UNLOADADDRESS), if2.wr_en, int'(if2.wr_addr), if2.busy, if2.done);
    end
  end

  // Per-test recording, used for the hand-computed expectations.
  int rec;
  int wq1[$], wi1[$], ui1[$], wq2[$];
  int d1, d2;

  task automatic clear_rec();
    rec = 0; d1 = 0; d2 = 0;
    wq1.delete(); wi1.delete(); ui1.delete(); wq2.delete();
  endtask

  // One cycle: drive inputs just after the rising edge, record outputs at the falling edge.
  task automatic cyc(input logic s, input logic a);
    @(posedge clk);
    #2;
    start = s;
    afull = a;
    @(negedge clk);
    if (if1.wr_en) begin wq1.push_back(int'(if1.wr_addr)); wi1.push_back(rec); end
    if (if1.unload_en) ui1.push_back(rec);
    if (if2.wr_en) wq2.push_back(int'(if2.wr_addr));
    if (if1.done) d1++;
    if (if2.done) d2++;
    rec++;
  endtask

  function automatic int qfirst(input int q[$]);
    return (q.size() == 0) ? -1 : q[0];
  endfunction

  function automatic int qlast(input int q[$]);
    return (q.size() == 0) ? -1 : q[q.size() - 1];
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (q.size() <= i) ? -1 : q[i];
  endfunction

  task automatic check_seq(input string name, input int q[$], input int n);
    int bad;
    bad = -1;
    check({name, "_count"}, q.size(), n);
    for (int i = 0; i < q.size(); i++) begin
      if (bad < 0 && q[i] != i) bad = i;
    end
    check({name, "_first_out_of_order"}, bad, -1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation ran to %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    afull = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset_lit1", if1.unload_en, int'(if1.UNLOADADDRESS), if1.wr_en, int'(if1.wr_addr), if1.busy, if1.done);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);

    // Nominal frame from a one-cycle start pulse.
    clear_rec();
    cyc(1'b1, 1'b0);
    repeat (40) cyc(1'b0, 1'b0);
    check_seq("nom1_addr", wq1, 16);
    check("nom1_first_ue_cycle", qfirst(ui1), 1);
    check("nom1_first_wr_cycle", qfirst(wi1), 2);
    check("nom1_last_wr_cycle", qlast(wi1), 17);
    check("nom1_done_cycles", d1, 10);
    check("nom1_busy_end", int'(if1.busy), 0);
    check_seq("nom2_addr", wq2, 2);
    check("nom2_done_cycles", d2, 2);

    // Start held for 60 cycles: one frame only, done held through the wait.
    clear_rec();
    repeat (60) cyc(1'b1, 1'b0);
    repeat (30) cyc(1'b0, 1'b0);
    check_seq("held1_addr", wq1, 16);
    check("held1_done_cycles", d1, 53);
    check_seq("held2_addr", wq2, 2);
    check("held2_done_cycles", d2, 59);

    // Almost-full for 5 cycles while column 6 is presented.
    clear_rec();
    for (int i = 0; i < 40; i++) cyc(i == 0, (i >= 7) && (i <= 11));
    check_seq("bp1_addr", wq1, 16);
    check("bp1_wr6_cycle", qat(wi1, 6), 8);
    check("bp1_wr7_cycle", qat(wi1, 7), 14);
    check("bp1_last_wr_cycle", qlast(wi1), 22);
    check("bp1_gap_cycles", qlast(wi1) - qfirst(wi1) + 1 - wi1.size(), 5);
    check("bp1_done_cycles", d1, 10);

    // FIFO almost-full while start is already high in IDLE.
    clear_rec();
    repeat (5) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    repeat (35) cyc(1'b0, 1'b0);
    check("full1_first_ue_cycle", qfirst(ui1), 6);
    check("full1_first_wr_cycle", qfirst(wi1), 7);
    check_seq("full1_addr", wq1, 16);
    check_seq("full2_addr", wq2, 2);

    // Asynchronous reset while column 9 is presented.
    clear_rec();
    cyc(1'b1, 1'b0);
    repeat (10) cyc(1'b0, 1'b0);
    check("arst1_pre_ue", int'(if1.unload_en), 1);
    check("arst1_pre_addr", int'(if1.UNLOADADDRESS), 9);
    check("arst1_pre_writes", wq1.size(), 9);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("arst1_now", if1.unload_en, int'(if1.UNLOADADDRESS), if1.wr_en, int'(if1.wr_addr), if1.busy, if1.done);
    clear_rec();
    repeat (3) cyc(1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (20) cyc(1'b0, 1'b0);
    check("arst1_post_done_cycles", d1, 0);
    check("arst1_post_writes", wq1.size(), 0);
    check("arst2_post_done_cycles", d2, 0);
    clear_rec();
    cyc(1'b1, 1'b0);
    repeat (30) cyc(1'b0, 1'b0);
    check_seq("arst1_restart_addr", wq1, 16);
    check("arst1_restart_first_wr", qfirst(wi1), 2);
    check("arst1_restart_done_cycles", d1, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
